proc_launcher: RTL and testbench
================================

# proc_launcher

Host-side run controller for the 9-bit processor core, sitting at the opposite end of its `start`/`Done` handshake. It accepts a run request, drives `start` for a programmed number of cycles to reset the core's PC, and then waits for `Done`. It counts execution cycles, enforces a timeout and reports completion with a one-cycle pulse plus latched status. Testbenches and any future multi-program host logic instantiate it instead of hand-driving `start`.

## Interface
- `START_CYCLES`, default 2: cycles `start` is held high per run; legal range 1..15.
- `TIMEOUT`, default 1000: maximum RUN cycles before the run is declared hung; legal range 1..2^CW-1.
- `CW`, default 16: width of the cycle counter.

- `Clk` in 1: the block's single clock.
- `Rst_n` in 1: reset, asynchronous and active-low.
- `req` in 1: run request, level-sensitive, sampled only in IDLE.
- `abort` in 1: abandon the current run.
- `Done` in 1: completion flag from the processor core.
- `start` out 1: start/reset line to the processor core.
- `busy` out 1: high in every state except IDLE.
- `run_done` out 1: one-cycle pulse when a run finishes or times out.
- `timed_out` out 1: latched; 1 if the last reported run hit `TIMEOUT`.
- `cycles` out CW: latched RUN-cycle count of the last reported run.
- `run_count` out 8: number of reported runs; wraps from 255 to 0.

## Operation
- States are IDLE, START, RUN and REPORT.
- **IDLE:** `start`=0 and `busy`=0. When `req`=1, go to START, load the start counter with `START_CYCLES`-1 and clear the cycle counter.
- **START:** `start`=1 and `Done` is ignored, because it may still be high from the previous run. When the start counter reaches 0, go to RUN; otherwise decrement it.
- **RUN:** `start`=0.
  - If `Done`=1, latch `cycles` from the counter, set `timed_out`=0 and go to REPORT.
  - If `Done`=0 and the counter equals `TIMEOUT`-1, latch `cycles`=`TIMEOUT`, set `timed_out`=1 and go to REPORT.
  - Otherwise increment the counter.
- **REPORT:** `run_done`=1 for exactly this cycle and `run_count` increments. The next state is always IDLE.
- If `req` is still high in IDLE, a new run starts on the next edge. There is therefore a minimum gap of one IDLE cycle between runs.
- `abort`=1 in START, RUN or REPORT forces IDLE on the next edge, and `start` drops at that edge.
  - An abort in START or RUN produces no `run_done` pulse and leaves `cycles`, `timed_out` and `run_count` unchanged.
  - An abort in REPORT does not cancel the pulse or the increment already in progress.
- If `Done` and the timeout condition occur in the same RUN cycle, `Done` wins: the run is reported as a normal completion.
- `abort` has priority over `Done` and over the timeout.
- `timed_out` and `cycles` hold their values until the next REPORT.

## Timing
- Reset values: state IDLE; `start`=0, `busy`=0, `run_done`=0, `timed_out`=0, `cycles`=0, `run_count`=0.
- Reset is asynchronous and may be asserted mid-run. All outputs return to their reset values immediately, and `start` drops without waiting for a clock edge.
- From `req` sampled in IDLE at edge N:
  - `start`=1 during cycles N+1 .. N+`START_CYCLES`.
  - RUN begins at cycle N+`START_CYCLES`+1.
- If `Done` is first seen high k cycles after RUN entry (k ≥ 0), then `cycles`=k and `run_done` is high during cycle N+`START_CYCLES`+k+2.
- All outputs are registered or decoded from state only. There is no combinational path from `Done` to any output.

## Structure
- The shared package `launcher_pkg` holds:
  - the state enum `launch_state_t` (IDLE, START, RUN, REPORT);
  - the default constants `LAUNCH_START_CYCLES` and `LAUNCH_TIMEOUT`.
- The block is a single module with no sub-modules. It contains the FSM, a 4-bit start counter, a CW-bit cycle counter and the status registers.

## Test plan
- Normal run: `req` pulses while the core model raises `Done` 5 RUN cycles after `start` falls. Required: `start` high for 2 cycles, `cycles`=5, `timed_out`=0, one `run_done` pulse, `run_count`=1.
- Stale `Done`: `Done` is held at 1 when `req` arrives and falls during START. Required: no early completion and `run_done` only after a fresh `Done`.
- Timeout: `TIMEOUT`=8 and `Done` never rises. Required: `run_done` pulses, `timed_out`=1, `cycles`=8, `run_count`=1.
- Simultaneous events: `TIMEOUT`=8 and `Done` rises in the RUN cycle where the counter equals 7. Required: `timed_out`=0 and `cycles`=7.
- Abort and reset: `abort` in RUN cycle 3 gives IDLE on the next edge with no pulse and `run_count` unchanged. `Rst_n` low mid-RUN drops `start`/`busy` asynchronously and clears `run_count`.
- Back-to-back: `req` is held high for 3 runs. Required: `run_count`=3, `run_done` pulsing once per run, and exactly one IDLE cycle between runs.

Source files
------------

// File: rtl/launcher_pkg.sv
// Shared types and default constants for the processor run launcher.
package launcher_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      REPORT
   } launch_state_t;

   localparam int unsigned LAUNCH_START_CYCLES = 2;
   localparam int unsigned LAUNCH_TIMEOUT      = 1000;

endpackage

// File: rtl/proc_launcher.sv
// Host-side run controller: pulses start to reset the core, waits for Done,
// counts RUN cycles with a timeout and reports completion status.
module proc_launcher
   import launcher_pkg::*;
#(
   parameter int unsigned START_CYCLES = LAUNCH_START_CYCLES,
   parameter int unsigned TIMEOUT      = LAUNCH_TIMEOUT,
   parameter int unsigned CW           = 16
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          req,
   input  logic          abort,
   input  logic          Done,
   output logic          start,
   output logic          busy,
   output logic          run_done,
   output logic          timed_out,
   output logic [CW-1:0] cycles,
   output logic [7:0]    run_count
);

   localparam logic [3:0]    START_LOAD   = 4'(START_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TIMEOUT_VAL  = CW'(TIMEOUT);

   launch_state_t state;
   launch_state_t state_next;
   logic [3:0]    start_cnt;
   logic [CW-1:0] cyc_cnt;
   logic          hit_timeout;

   always_comb begin
      hit_timeout = (cyc_cnt == TIMEOUT_LAST);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // abort outranks Done and timeout; Done outranks timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) state_next = START;
         end
         START: begin
            if (abort)                state_next = IDLE;
            else if (start_cnt == '0) state_next = RUN;
         end
         RUN: begin
            if (abort)                     state_next = IDLE;
            else if (Done || hit_timeout)  state_next = REPORT;
         end
         REPORT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from state alone so reset clears them without a clock.
   always_comb begin
      start    = (state == START);
      busy     = (state != IDLE);
      run_done = (state == REPORT);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         start_cnt <= '0;
         cyc_cnt   <= '0;
         cycles    <= '0;
         timed_out <= 1'b0;
         run_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  start_cnt <= START_LOAD;
                  cyc_cnt   <= '0;
               end
            end
            START: begin
               if (!abort && start_cnt != '0) begin
                  start_cnt <= start_cnt - 4'd1;
               end
            end
            RUN: begin
               if (!abort) begin
                  if (Done) begin
                     cycles    <= cyc_cnt;
                     timed_out <= 1'b0;
                  end else if (hit_timeout) begin
                     cycles    <= TIMEOUT_VAL;
                     timed_out <= 1'b1;
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
            end
            REPORT: begin
               run_count <= run_count + 8'd1;
            end
            default: begin
               start_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_launcher.sv
// Self-checking bench for proc_launcher: scenario tasks plus a scoreboard
// that checks every run_done pulse against queued expectations.
module tb_proc_launcher;

   localparam int unsigned SC = 2;
   localparam int unsigned TO = 8;
   localparam int unsigned CW = 16;

   typedef struct {
      int unsigned cyc;
      logic        to;
      int unsigned cnt;
   } exp_t;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          req = 1'b0;
   logic          abort = 1'b0;
   logic          Done = 1'b0;
   logic          start;
   logic          busy;
   logic          run_done;
   logic          timed_out;
   logic [CW-1:0] cycles;
   logic [7:0]    run_count;

   int          checks = 0;
   int          failures = 0;
   int unsigned exp_count = 0;
   exp_t        q[$];
   exp_t        e;
   logic        prev_done = 1'b0;

   proc_launcher #(
      .START_CYCLES(SC),
      .TIMEOUT     (TO),
      .CW          (CW)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .req      (req),
      .abort    (abort),
      .Done     (Done),
      .start    (start),
      .busy     (busy),
      .run_done (run_done),
      .timed_out(timed_out),
      .cycles   (cycles),
      .run_count(run_count)
   );

   always #5 Clk = ~Clk;

   // Scoreboard: every pulse must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (!Rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (run_done === 1'b1) begin
            checks++;
            if (prev_done) begin
               failures++;
               $display("FAIL run_done_width got=2+ cycles exp=1 cycle");
            end
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_run_done got=pulse exp=none");
            end else begin
               e = q.pop_front();
               checks++;
               if (cycles !== CW'(e.cyc)) begin
                  failures++;
                  $display("FAIL sb_cycles got=%0d exp=%0d", cycles, e.cyc);
               end
               checks++;
               if (timed_out !== e.to) begin
                  failures++;
                  $display("FAIL sb_timed_out got=%0b exp=%0b", timed_out, e.to);
               end
               checks++;
               if (run_count !== 8'(e.cnt - 1)) begin
                  failures++;
                  $display("FAIL sb_run_count_before got=%0d exp=%0d", run_count, e.cnt - 1);
               end
            end
         end
         prev_done = run_done;
      end
   end

   task automatic apply_reset();
      req = 1'b0; abort = 1'b0; Done = 1'b0;
      Rst_n = 1'b0;
      q.delete();
      exp_count = 0;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
   endtask

   // One run from IDLE; k = RUN cycle where Done is raised, or timeout when to=1.
   task automatic run_once(input string name, input int unsigned k, input bit stale,
                           input bit to, input bit hold);
      int sc;
      int lat;
      if (stale) Done = 1'b1;
      req = 1'b1;
      @(negedge Clk);
      if (!hold) req = 1'b0;
      sc = 0;
      while (start === 1'b1 && sc < 20) begin
         sc++;
         if (stale && sc == 2) Done = 1'b0;
         @(negedge Clk);
      end
      checks++;
      if (sc != int'(SC)) begin
         failures++;
         $display("FAIL %s start_len got=%0d exp=%0d", name, sc, SC);
      end
      checks++;
      if (busy !== 1'b1 || start !== 1'b0) begin
         failures++;
         $display("FAIL %s run_entry got=busy%0b/start%0b exp=busy1/start0", name, busy, start);
      end
      if (!to) begin
         repeat (k) @(negedge Clk);
         exp_count++;
         q.push_back('{k, 1'b0, exp_count});
         Done = 1'b1;
         lat = int'(k);
      end else begin
         exp_count++;
         q.push_back('{TO, 1'b1, exp_count});
         lat = 0;
      end
      do begin
         @(negedge Clk);
         lat++;
      end while (run_done !== 1'b1 && lat < 60);
      Done = 1'b0;
      checks++;
      if (lat != (to ? int'(TO) : int'(k) + 1)) begin
         failures++;
         $display("FAIL %s report_latency got=%0d exp=%0d", name, lat, to ? TO : k + 1);
      end
      @(negedge Clk);
      checks++;
      if (busy !== 1'b0 || run_count !== 8'(exp_count)) begin
         failures++;
         $display("FAIL %s idle_after got=busy%0b/count%0d exp=busy0/count%0d",
                  name, busy, run_count, exp_count);
      end
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({start, busy, run_done, timed_out} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {start, busy, run_done, timed_out});
      end
      checks++;
      if (cycles !== '0 || run_count !== '0) begin
         failures++;
         $display("FAIL reset_counts got=%0d/%0d exp=0/0", cycles, run_count);
      end
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_no_req got=%0b exp=0", busy);
      end
   endtask

   task automatic test_normal();
      apply_reset();
      run_once("normal", 5, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cycles !== CW'(5) || timed_out !== 1'b0 || run_count !== 8'd1) begin
         failures++;
         $display("FAIL normal_status got=%0d/%0b/%0d exp=5/0/1", cycles, timed_out, run_count);
      end
   endtask

   task automatic test_stale_done();
      apply_reset();
      run_once("stale", 3, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      apply_reset();
      run_once("timeout", 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (cycles !== CW'(TO) || timed_out !== 1'b1 || run_count !== 8'd1) begin
         failures++;
         $display("FAIL timeout_status got=%0d/%0b/%0d exp=8/1/1", cycles, timed_out, run_count);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      run_once("simul", TO - 1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cycles !== CW'(TO - 1) || timed_out !== 1'b0) begin
         failures++;
         $display("FAIL simul_status got=%0d/%0b exp=7/0", cycles, timed_out);
      end
   endtask

   task automatic test_abort();
      int n;
      apply_reset();
      run_once("pre_abort", 4, 1'b0, 1'b0, 1'b0);
      req = 1'b1;
      @(negedge Clk);
      req = 1'b0;
      n = 0;
      while (start === 1'b1 && n < 20) begin
         n++;
         @(negedge Clk);
      end
      repeat (3) @(negedge Clk);
      abort = 1'b1;
      Done = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || start !== 1'b0 || run_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got=busy%0b/start%0b/done%0b exp=0/0/0", busy, start, run_done);
      end
      Done = 1'b0;
      repeat (6) @(negedge Clk);
      checks++;
      if (run_count !== 8'd1 || cycles !== CW'(4) || timed_out !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_hold got=%0d/%0d/%0b/%0b exp=1/4/0/0",
                  run_count, cycles, timed_out, busy);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      run_once("pre_reset", 1, 1'b0, 1'b0, 1'b0);
      req = 1'b1;
      @(negedge Clk);
      req = 1'b0;
      #2;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (start !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_lines got=start%0b/busy%0b exp=0/0", start, busy);
      end
      checks++;
      if (run_count !== 8'd0 || cycles !== '0) begin
         failures++;
         $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", run_count, cycles);
      end
      q.delete();
      exp_count = 0;
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      run_once("b2b_1", 2, 1'b0, 1'b0, 1'b1);
      run_once("b2b_2", 1, 1'b0, 1'b0, 1'b1);
      run_once("b2b_3", 3, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
      checks++;
      if (run_count !== 8'd3 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_final got=%0d/busy%0b exp=3/0", run_count, busy);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_stale_done();
      test_timeout();
      test_simultaneous();
      test_abort();
      test_async_reset();
      test_back_to_back();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
